// File: rtl/dff_err_scan.sv
// dff_err_scan: per-chain DFF mismatch counters against a delayed reference, with
// a snapshot frame shifted out serially on RPi save/data clock edges.
module dff_err_scan #(
  parameter int CHAN        = 20,
  parameter int CNT_W       = 12,
  parameter int LAT         = 2,
  parameter bit CLR_ON_SAVE = 1'b1
) (
  input  logic            CLK,
  input  logic            RST_B,
  input  logic            en,
  input  logic            clr,
  input  logic            data_ref,
  input  logic [CHAN-1:0] q_in,
  input  logic            save_req,
  input  logic            data_clk,
  output logic            data_out,
  output logic            busy,
  output logic            err_any
);
  localparam int FW = CHAN * CNT_W;
  localparam int BW = $clog2(FW + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic [LAT:0]     dl_q;
  logic [CHAN-1:0]  q_r_q, flag_q, inc;
  logic [CNT_W-1:0] cnt_q [CHAN];
  logic [FW-1:0]    cnt_flat, shadow_q, shadow_d;
  logic [BW-1:0]    bits_q, bits_d;
  logic [1:0]       state_q, state_d;
  logic [2:0]       sv_s_q, dc_s_q;
  logic             err_any_q, sv_p, dc_p, load;

  // top stage of the line is the aligned reference (LAT delays plus one register)
  assign inc  = {CHAN{en}} & (q_r_q ^ {CHAN{dl_q[LAT]}});
  assign sv_p = sv_s_q[1] & ~sv_s_q[2];
  assign dc_p = dc_s_q[1] & ~dc_s_q[2];
  assign load = state_q == LOAD;

  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < CHAN; i++) cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    bits_d   = bits_q;
    if (state_q == IDLE && sv_p) state_d = LOAD;
    if (load) begin
      shadow_d = cnt_flat;
      bits_d   = '0;
      state_d  = SHIFT;
    end
    if (state_q == SHIFT && dc_p) begin
      shadow_d = shadow_q << 1;
      bits_d   = bits_q + BW'(1);
      state_d  = (bits_q == BW'(FW - 1)) ? IDLE : SHIFT;
    end
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      dl_q      <= '0;
      q_r_q     <= '0;
      flag_q    <= '0;
      err_any_q <= 1'b0;
      sv_s_q    <= '0;
      dc_s_q    <= '0;
      state_q   <= IDLE;
      shadow_q  <= '0;
      bits_q    <= '0;
      for (int i = 0; i < CHAN; i++) cnt_q[i] <= '0;
    end else begin
      dl_q      <= (dl_q << 1) | (LAT+1)'(data_ref);
      q_r_q     <= q_in;
      flag_q    <= clr ? '0 : (flag_q | inc);
      err_any_q <= |flag_q;
      sv_s_q    <= {sv_s_q[1:0], save_req};
      dc_s_q    <= {dc_s_q[1:0], data_clk};
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      bits_q    <= bits_d;
      // a mismatch on the snapshot edge restarts the count at 1 so it is not lost
      for (int i = 0; i < CHAN; i++)
        if (clr) cnt_q[i] <= '0;
        else if (load && CLR_ON_SAVE) cnt_q[i] <= CNT_W'(inc[i]);
        else if (inc[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  assign busy     = state_q == SHIFT;
  assign data_out = busy & shadow_q[FW-1];
  assign err_any  = err_any_q;
endmodule

// File: tb/tb_dff_err_scan.sv
// tb_dff_err_scan: directed checks of counting, saturation, snapshot framing,
// clr/en handling, ignored saves and mid-shift reset for dff_err_scan.
module tb_dff_err_scan;
  localparam int CHAN  = 20;
  localparam int CNT_W = 12;
  localparam int FW    = CHAN * CNT_W;

  logic            CLK = 1'b0;
  logic            RST_B, en, clr, data_ref, save_req, data_clk;
  logic [CHAN-1:0] q_in, emask;
  logic            data_out, busy, err_any;
  logic [2:0]      h;
  logic [FW-1:0]   fr;
  int              idx;
  int              n_chk = 0;
  int              n_fail = 0;

  dff_err_scan #(.CHAN(CHAN), .CNT_W(CNT_W), .LAT(2), .CLR_ON_SAVE(1'b1)) dut (
    .CLK(CLK), .RST_B(RST_B), .en(en), .clr(clr), .data_ref(data_ref), .q_in(q_in),
    .save_req(save_req), .data_clk(data_clk), .data_out(data_out), .busy(busy),
    .err_any(err_any)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [FW-1:0] o, input logic [FW-1:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // q_in follows data_ref two cycles late, inverted where emask is set
  task automatic tick();
    h        = {h[1:0], 1'($urandom)};
    data_ref = h[0];
    q_in     = {CHAN{h[2]}} ^ emask;
    @(negedge CLK);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [FW-1:0] field(input int ch, input int v);
    logic [FW-1:0] f;
    f = '0;
    f[ch*CNT_W +: CNT_W] = CNT_W'(v);
    return f;
  endfunction

  task automatic pulse_save(input logic [CHAN-1:0] m3);
    save_req = 1'b1;
    ticks(2);
    emask = m3;
    tick();
    emask = '0;
    save_req = 1'b0;
    ticks(3);
  endtask

  task automatic shift_bits(input int n);
    for (int i = 0; i < n; i++) begin
      fr[FW-1-idx] = data_out;
      idx++;
      data_clk = 1'b1;
      ticks(3);
      data_clk = 1'b0;
      ticks(3);
    end
  endtask

  task automatic read_frame(input string tag, input logic [FW-1:0] e, input logic [CHAN-1:0] m3);
    pulse_save(m3);
    chk({tag, " busy_rise"}, FW'(busy), FW'(1));
    fr = '0;
    idx = 0;
    shift_bits(FW);
    chk({tag, " frame"}, fr, e);
    chk({tag, " busy_fall"}, FW'(busy), FW'(0));
    chk({tag, " dout_idle"}, FW'(data_out), FW'(0));
  endtask

  initial begin
    RST_B = 1'b0; en = 1'b0; clr = 1'b0; save_req = 1'b0; data_clk = 1'b0;
    emask = '0; h = '0; data_ref = 1'b0; q_in = '0;
    ticks(3);
    chk("rst data_out", FW'(data_out), FW'(0));
    chk("rst busy", FW'(busy), FW'(0));
    chk("rst err_any", FW'(err_any), FW'(0));
    RST_B = 1'b1;
    ticks(4);
    en = 1'b1;
    ticks(1000);
    chk("clean err_any", FW'(err_any), FW'(0));
    read_frame("clean", '0, '0);

    emask = CHAN'(1) << 3;
    ticks(5);
    emask = '0;
    ticks(4);
    chk("ch3 err_any", FW'(err_any), FW'(1));
    read_frame("ch3", field(3, 5), '0);

    emask = CHAN'(1);
    ticks(4100);
    emask = '0;
    ticks(4);
    read_frame("sat", field(0, 4095), '0);
    read_frame("sat_cleared", '0, '0);

    emask = CHAN'(1) << 2;
    ticks(3);
    emask = '0;
    ticks(4);
    read_frame("load_edge", field(2, 3), CHAN'(1) << 2);
    read_frame("load_edge_live", field(2, 1), '0);

    emask = CHAN'(1) << 5;
    ticks(2);
    emask = '0;
    ticks(4);
    emask = CHAN'(1) << 5;
    clr = 1'b1;
    tick();
    emask = '0;
    ticks(2);
    clr = 1'b0;
    ticks(3);
    chk("clr err_any", FW'(err_any), FW'(0));
    read_frame("clr", '0, '0);

    en = 1'b0;
    emask = CHAN'(1) << 7;
    ticks(10);
    emask = '0;
    ticks(3);
    en = 1'b1;
    ticks(2);
    chk("en_off err_any", FW'(err_any), FW'(0));
    read_frame("en_off", '0, '0);

    emask = CHAN'(1) << 19;
    ticks(6);
    emask = '0;
    ticks(4);
    pulse_save('0);
    chk("mid busy_rise", FW'(busy), FW'(1));
    fr = '0;
    idx = 0;
    shift_bits(20);
    pulse_save('0);
    chk("mid save_ignored busy", FW'(busy), FW'(1));
    emask = CHAN'(1);
    shift_bits(3);
    emask = '0;
    shift_bits(14);
    chk("mid prefix37", FW'(fr[FW-1 -: 37]), FW'(field(19, 6) >> (FW - 37)));
    chk("mid err_any", FW'(err_any), FW'(1));
    RST_B = 1'b0;
    #1;
    chk("mid rst busy", FW'(busy), FW'(0));
    chk("mid rst data_out", FW'(data_out), FW'(0));
    chk("mid rst err_any", FW'(err_any), FW'(0));
    en = 1'b0;
    ticks(2);
    RST_B = 1'b1;
    ticks(4);
    en = 1'b1;
    ticks(4);
    read_frame("post_rst", '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
